dump_gate_ctrl: RTL and testbench
=================================

# dump_gate_ctrl

Drive-side stage for the Q-dump switch. Consumes the `dump_on` request produced by the dump on/off sequencing block and turns it into the actual dump-switch gate signal. Enforces a dead-time interlock against the transmitter enable, a maximum on-time watchdog and a sticky fault. Reports the length of the last dump pulse to the control logic.

## Interface
Parameters:
- `DEAD_CYC`, 8: dead-time in `clk_sys` cycles, applied before gate-on and after gate-off; legal range 1..65535.
- `MAX_ON_CYC`, 2000: maximum gate-high duration in cycles; legal range 1..65535.

Ports:
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dump_on`  in  1  dump request, level; synchronous to `clk_sys`.
- `tx_on`  in  1  transmitter enable, level; synchronous to `clk_sys`.
- `fault_clr`  in  1  single-cycle fault clear pulse.
- `dump_gate`  out  1  dump switch gate drive, registered.
- `tx_inhibit`  out  1  high while the dump path owns the coil, registered.
- `fault`  out  1  sticky fault flag, registered.
- `on_len`  out  16  gate-high cycle count of the last completed or aborted dump pulse, registered.

## Operation
- State machine states:
  - IDLE: gate 0, inhibit 0.
  - ARM: dead-time before on; inhibit 1.
  - ON: gate 1, inhibit 1.
  - HOLD: dead-time after off; inhibit 1.
  - FAULT: gate 0, inhibit 0, fault 1.
- Internal 16-bit `dead_cnt` and 16-bit `on_cnt`.
- IDLE → ARM when `dump_on`=1 and `tx_on`=0. On entry, `dead_cnt` is loaded with DEAD_CYC-1.
  - If `dump_on`=1 and `tx_on`=1, the block stays in IDLE. This is a held-off request, not a fault.
- ARM:
  - `dump_on`=0 → IDLE.
  - `tx_on`=1 → IDLE. The request re-arms from scratch once `tx_on` drops.
  - Otherwise `dead_cnt` decrements. When `dead_cnt`=0 → ON; `on_cnt` is loaded with 1.
- ON, priority highest first:
  1. `tx_on`=1 → FAULT.
  2. `on_cnt`=MAX_ON_CYC and `dump_on`=1 → FAULT.
  3. `dump_on`=0 → HOLD, with `dead_cnt` loaded with DEAD_CYC-1.
  4. Else `on_cnt` increments.
- HOLD: `dead_cnt` decrements; at 0 → IDLE.
  - `dump_on` is ignored in HOLD.
  - `tx_on`=1 in HOLD does not fault; inhibit stays asserted.
- FAULT: exits to IDLE only when `fault_clr`=1 and `dump_on`=0 in the same cycle. Otherwise the block remains in FAULT.
- `on_len` is captured from `on_cnt` on every exit from ON (to HOLD or FAULT). It holds its value otherwise.
- `on_cnt` never exceeds MAX_ON_CYC.
- `fault_clr` outside FAULT has no effect.

## Timing
- Reset values: state IDLE, `dump_gate`=0, `tx_inhibit`=0, `fault`=0, `on_len`=0, counters 0.
- Reset asserted mid-pulse forces `dump_gate` low immediately, asynchronously.
- Let E0 be the first edge sampling `dump_on`=1 with `tx_on`=0 in IDLE.
  - `tx_inhibit` rises after E0.
  - `dump_gate` rises after edge E0+DEAD_CYC, provided both conditions held through every intervening edge.
- Gate high duration equals the number of edges sampled in ON, i.e. `on_len`. It is at most MAX_ON_CYC.
- Normal turn-off (edge E1 samples `dump_on`=0 in ON):
  - `dump_gate` falls after E1.
  - `tx_inhibit` falls after E1+DEAD_CYC.
- Interlock (edge samples `tx_on`=1 in ON): `dump_gate` falls and `fault` rises after that same edge. This is one cycle of latency.
- Simultaneous `tx_on` rise and `dump_on` fall in ON → FAULT. The interlock has priority.
- Watchdog: `dump_on` held high indefinitely gives exactly MAX_ON_CYC gate-high cycles, then FAULT with `on_len`=MAX_ON_CYC.
- `fault` falls after the edge that samples `fault_clr`=1 with `dump_on`=0.

## Test plan
- Reset, then `dump_on` high for 50 cycles with `tx_on`=0, DEAD_CYC=8. Required:
  - gate rises 8 cycles after E0 and is high for 42 cycles;
  - inhibit stays high 8 cycles past gate fall;
  - `on_len`=42, `fault`=0.
- `dump_on` high for 5 cycles (less than DEAD_CYC=8). Required:
  - gate never rises;
  - state returns to IDLE;
  - `on_len` unchanged.
- `tx_on`=1 while `dump_on` rises, `tx_on` drops 20 cycles later. Required: gate rises 8 cycles after `tx_on` falls, with no fault.
- `tx_on` pulses high for 1 cycle 10 cycles into ON. Required:
  - gate low on the next cycle;
  - `fault`=1 and `on_len`=10;
  - `fault_clr` with `dump_on`=1 is ignored;
  - `fault_clr` with `dump_on`=0 clears the fault.
- MAX_ON_CYC=100 with `dump_on` held high. Required: gate high exactly 100 cycles, then `fault`=1 and `on_len`=100.
- `rst_n` asserted mid-ON. Required: gate low asynchronously, all outputs at reset values, normal operation on the next request.

Source files
------------

// File: rtl/dump_gate_ctrl.sv
// Dump-switch gate driver: turns the dump_on request into a gate drive with
// dead-time interlock against tx_on, a max on-time watchdog and a sticky fault.
module dump_gate_ctrl #(
  parameter int DEAD_CYC   = 8,
  parameter int MAX_ON_CYC = 2000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        dump_on,
  input  logic        tx_on,
  input  logic        fault_clr,
  output logic        dump_gate,
  output logic        tx_inhibit,
  output logic        fault,
  output logic [15:0] on_len
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ON    = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYC - 1);
  localparam logic [15:0] MAX_ON    = 16'(MAX_ON_CYC);

  state_t      state_q, state_d;
  logic [15:0] dead_cnt_q, dead_cnt_d;
  logic [15:0] on_cnt_q, on_cnt_d;
  logic [15:0] on_len_q, on_len_d;
  logic        gate_q, gate_d;
  logic        inhibit_q, inhibit_d;
  logic        fault_q, fault_d;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    on_cnt_d   = on_cnt_q;
    on_len_d   = on_len_q;
    case (state_q)
      S_IDLE: begin
        if (dump_on && !tx_on) begin
          state_d    = S_ARM;
          dead_cnt_d = DEAD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (!dump_on || tx_on) begin
          state_d = S_IDLE;
        end else if (dead_cnt_q == 16'd0) begin
          state_d  = S_ON;
          on_cnt_d = 16'd1;
        end else begin
          dead_cnt_d = dead_cnt_q - 16'd1;
        end
      end
      S_ON: begin
        // Interlock beats watchdog beats normal turn-off
        if (tx_on) begin
          state_d  = S_FAULT;
          on_len_d = on_cnt_q;
        end else if ((on_cnt_q == MAX_ON) && dump_on) begin
          state_d  = S_FAULT;
          on_len_d = on_cnt_q;
        end else if (!dump_on) begin
          state_d    = S_HOLD;
          dead_cnt_d = DEAD_LOAD;
          on_len_d   = on_cnt_q;
        end else if (on_cnt_q < MAX_ON) begin
          on_cnt_d = on_cnt_q + 16'd1;
        end else begin
          on_cnt_d = on_cnt_q;
        end
      end
      S_HOLD: begin
        if (dead_cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q - 16'd1;
        end
      end
      S_FAULT: begin
        if (fault_clr && !dump_on) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    gate_d    = (state_d == S_ON);
    inhibit_d = (state_d == S_ARM) || (state_d == S_ON) || (state_d == S_HOLD);
    fault_d   = (state_d == S_FAULT);
  end

  // State, counter and output registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dead_cnt_q <= 16'd0;
      on_cnt_q   <= 16'd0;
      on_len_q   <= 16'd0;
      gate_q     <= 1'b0;
      inhibit_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      on_cnt_q   <= on_cnt_d;
      on_len_q   <= on_len_d;
      gate_q     <= gate_d;
      inhibit_q  <= inhibit_d;
      fault_q    <= fault_d;
    end
  end

  assign dump_gate  = gate_q;
  assign tx_inhibit = inhibit_q;
  assign fault      = fault_q;
  assign on_len     = on_len_q;

endmodule

// File: tb/tb_dump_gate_ctrl.sv
// Self-checking bench for dump_gate_ctrl: directed test-plan scenarios with literal
// expectations, then random stimulus, all checked every cycle against a timing model.
module tb_dump_gate_ctrl;
  localparam int DEAD  = 8;
  localparam int MAXON = 100;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_on = 1'b0;
  logic        tx_on = 1'b0;
  logic        fault_clr = 1'b0;
  logic        dump_gate, tx_inhibit, fault;
  logic [15:0] on_len;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: which phase of a dump pulse we are in and how many edges it has lasted
  bit m_arm, m_on, m_hold, m_fault;
  int m_wait, m_on_edges, m_hold_edges, m_len;

  dump_gate_ctrl #(.DEAD_CYC(DEAD), .MAX_ON_CYC(MAXON)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .dump_on(dump_on), .tx_on(tx_on),
    .fault_clr(fault_clr), .dump_gate(dump_gate), .tx_inhibit(tx_inhibit),
    .fault(fault), .on_len(on_len)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_arm = 0; m_on = 0; m_hold = 0; m_fault = 0;
    m_wait = 0; m_on_edges = 0; m_hold_edges = 0; m_len = 0;
  endtask

  // One clock edge of the model, using the inputs sampled at that edge
  task automatic model_step();
    bit d = dump_on;
    bit t = tx_on;
    bit c = fault_clr;
    if (m_fault) begin
      if (c && !d) m_fault = 0;
    end else if (m_on) begin
      m_on_edges++;
      if (t || (m_on_edges == MAXON && d)) begin
        m_on = 0; m_fault = 1; m_len = m_on_edges;
      end else if (!d) begin
        m_on = 0; m_hold = 1; m_hold_edges = 0; m_len = m_on_edges;
      end
    end else if (m_hold) begin
      m_hold_edges++;
      if (m_hold_edges == DEAD) m_hold = 0;
    end else if (m_arm) begin
      if (!d || t) begin
        m_arm = 0;
      end else begin
        m_wait++;
        if (m_wait == DEAD) begin
          m_arm = 0; m_on = 1; m_on_edges = 0;
        end
      end
    end else if (d && !t) begin
      m_arm = 1; m_wait = 0;
    end
  endtask

  task automatic tick(input bit d, input bit t, input bit c);
    dump_on = d; tx_on = t; fault_clr = c;
    @(posedge clk_sys);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk_sys);
  endtask

  // Cycle-by-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_en && rst_n) begin
        check("gate", int'(dump_gate), int'(m_on));
        check("inhibit", int'(tx_inhibit), int'(m_arm | m_on | m_hold));
        check("fault", int'(fault), int'(m_fault));
        check("on_len", int'(on_len), m_len);
      end
    end
  end

  initial begin
    int rise, hi, inh;
    bit rd, rt, rc;
    model_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("rst_gate", int'(dump_gate), 0);
    check("rst_inhibit", int'(tx_inhibit), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_on_len", int'(on_len), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(0, 0, 0);

    // 50-cycle request
    rise = -1; hi = 0; inh = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1, 0, 0);
      if (dump_gate) begin hi++; if (rise < 0) rise = k; end
    end
    check("s1_rise", rise, 8);
    for (int k = 0; k < 12; k++) begin
      tick(0, 0, 0);
      if (dump_gate) hi++;
      if (tx_inhibit && !dump_gate) inh++;
    end
    check("s1_high", hi, 42);
    check("s1_inh_tail", inh, 8);
    check("s1_on_len", int'(on_len), 42);
    check("s1_fault", int'(fault), 0);

    // Request shorter than the dead-time
    hi = 0;
    for (int k = 0; k < 5; k++) begin tick(1, 0, 0); hi += int'(dump_gate); end
    for (int k = 0; k < 10; k++) begin tick(0, 0, 0); hi += int'(dump_gate); end
    check("s2_high", hi, 0);
    check("s2_inhibit", int'(tx_inhibit), 0);
    check("s2_on_len", int'(on_len), 42);

    // Held off by tx_on, then interlock trip 10 cycles into ON
    hi = 0;
    for (int k = 0; k < 20; k++) begin tick(1, 1, 0); hi += int'(dump_gate) + int'(tx_inhibit); end
    check("s3_held", hi, 0);
    rise = -1;
    for (int k = 0; k < 9; k++) begin
      tick(1, 0, 0);
      if (dump_gate && rise < 0) rise = k;
    end
    check("s3_rise", rise, 8);
    check("s3_fault", int'(fault), 0);
    for (int k = 0; k < 9; k++) tick(1, 0, 0);
    tick(1, 1, 0);
    check("s4_gate", int'(dump_gate), 0);
    check("s4_fault", int'(fault), 1);
    check("s4_on_len", int'(on_len), 10);
    tick(1, 0, 1);
    check("s4_clr_ignored", int'(fault), 1);
    tick(0, 0, 1);
    check("s4_clr", int'(fault), 0);
    tick(0, 0, 0);

    // Watchdog
    rise = -1; hi = 0;
    for (int k = 0; k < 300; k++) begin
      tick(1, 0, 0);
      if (dump_gate) begin hi++; if (rise < 0) rise = k; end
      if (fault) break;
    end
    check("s5_rise", rise, 8);
    check("s5_high", hi, 100);
    check("s5_fault", int'(fault), 1);
    check("s5_on_len", int'(on_len), 100);
    tick(0, 0, 1);
    check("s5_clr", int'(fault), 0);
    tick(0, 0, 0);

    // Reset in the middle of ON
    for (int k = 0; k < 20; k++) tick(1, 0, 0);
    check("s6_pre_gate", int'(dump_gate), 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_gate", int'(dump_gate), 0);
    check("s6_inhibit", int'(tx_inhibit), 0);
    check("s6_fault", int'(fault), 0);
    check("s6_on_len", int'(on_len), 0);
    model_reset();
    @(negedge clk_sys);
    tick(1, 0, 0);
    rst_n = 1'b1;
    rise = -1;
    for (int k = 0; k < 9; k++) begin
      tick(1, 0, 0);
      if (dump_gate && rise < 0) rise = k;
    end
    check("s6_rise", rise, 8);
    for (int k = 0; k < 12; k++) tick(0, 0, 0);

    // Random traffic against the model
    rd = 0; rt = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(59) == 0) rd = !rd;
      rt = ($urandom_range(79) == 0) ? 1'b1 : (rt && ($urandom_range(2) != 0));
      rc = ($urandom_range(7) == 0);
      tick(rd, rt, rc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
